// File: rtl/ram_rmw_ctrl_if.sv
// Request/response port of the RAM read-modify-write controller.
//
// Handshake: a request transfers at a rising clk edge where req_valid and
// req_ready are both 1. The initiator must hold req_* stable while
// req_valid=1 and req_ready=0. The controller takes one request at a time
// and answers it with a single-cycle rsp_valid pulse that cannot be stalled.
// rsp_rdata carries read data while rsp_valid=1 and holds its value otherwise.
interface ram_rmw_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_bmask;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;

  // Core side: issues requests and consumes responses
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_bmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_bmask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_rmw_ctrl.sv
// RAM initiator for a 16-bit RAM whose write port has no byte enables.
// Word writes go straight to the RAM; byte writes are done as
// read-modify-write. One request is outstanding at a time and every request
// ends in exactly one rsp_valid pulse.
//
// Optional feature macro: RAM_RMW_FWD_EN. When defined, the last word written
// is kept locally and a read or byte write to that address uses it instead
// of reading the RAM. This is only valid when this block is the RAM's sole
// writer.
//
// The FSM state is visible on dbg_state_o
// (0=IDLE, 1=RD, 2=WAIT, 3=WR, 4=RSP).
module ram_rmw_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int RD_LATENCY = 1   // legal range 1..3
) (
  input  logic              clk,
  input  logic              reset,
  ram_rmw_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [15:0]       ram_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [15:0]       ram_wdata,
  output logic              ram_write,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  // Extra WAIT cycles beyond the first data-wait cycle
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [1:0]        bmask_q;
  logic              write_q;
  logic [15:0]       merged_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_rdata_q;
  logic [ADDR_W-1:0] ram_raddr_q;
  logic [ADDR_W-1:0] ram_waddr_q;
  logic [15:0]       ram_wdata_q;
  logic              ram_write_q;

  logic              fwd_hit_d;
  logic [15:0]       fwd_rdata_d;
  logic [15:0]       wr_data_d;

  // New bytes where the mask is set, old bytes elsewhere
  function automatic logic [15:0] merge_bytes(input logic [15:0] new_d,
                                              input logic [15:0] old_d,
                                              input logic [1:0]  be);
    merge_bytes = {be[1] ? new_d[15:8] : old_d[15:8],
                   be[0] ? new_d[7:0]  : old_d[7:0]};
  endfunction

  // Word written by WR: a full write uses the request data unmerged
  assign wr_data_d = (bmask_q == 2'b11) ? wdata_q : merged_q;

`ifdef RAM_RMW_FWD_EN
  logic              fwd_vld_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [15:0]       fwd_data_q;

  assign fwd_hit_d   = fwd_vld_q && (fwd_addr_q == bus.req_addr);
  assign fwd_rdata_d = fwd_data_q;

  // Record of the most recent RAM write, refreshed by every WR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else if (state_q == S_WR) begin
      fwd_vld_q  <= 1'b1;
      fwd_addr_q <= addr_q;
      fwd_data_q <= wr_data_d;
    end
  end
`else
  assign fwd_hit_d   = 1'b0;
  assign fwd_rdata_d = 16'h0000;
`endif

  // Control FSM with registered RAM and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      write_q     <= 1'b0;
      merged_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_raddr_q <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_write_q <= 1'b0;
    end else begin
      ram_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            bmask_q <= bus.req_bmask;
            write_q <= bus.req_write;
            if (!bus.req_write) begin
              if (fwd_hit_d) begin
                rsp_rdata_q <= fwd_rdata_d;
                state_q     <= S_RSP;
              end else begin
                // Read address is presented during RD so a 1-cycle RAM
                // returns data in the first WAIT cycle.
                ram_raddr_q <= bus.req_addr;
                state_q     <= S_RD;
              end
            end else if (bus.req_bmask == 2'b00) begin
              state_q <= S_RSP;
            end else if (bus.req_bmask == 2'b11) begin
              state_q <= S_WR;
            end else if (fwd_hit_d) begin
              merged_q <= merge_bytes(bus.req_wdata, fwd_rdata_d, bus.req_bmask);
              state_q  <= S_WR;
            end else begin
              ram_raddr_q <= bus.req_addr;
              state_q     <= S_RD;
            end
          end
        end
        S_RD: begin
          cnt_q   <= CNT_INIT;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else if (!write_q) begin
            rsp_rdata_q <= ram_rdata;
            state_q     <= S_RSP;
          end else begin
            merged_q <= merge_bytes(wdata_q, ram_rdata, bmask_q);
            state_q  <= S_WR;
          end
        end
        S_WR: begin
          ram_write_q <= 1'b1;
          ram_waddr_q <= addr_q;
          ram_wdata_q <= wr_data_d;
          state_q     <= S_RSP;
        end
        S_RSP: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = !reset && (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ram_raddr     = ram_raddr_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_write     = ram_write_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Bench for ram_rmw_ctrl: one instance with RD_LATENCY=1, one with
// RD_LATENCY=3, each connected to a behavioural RAM of matching latency.
module tb_ram_rmw_ctrl;

`ifdef RAM_RMW_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        v_sel;
  logic        v_valid;
  logic        v_write;
  logic [4:0]  v_addr;
  logic [15:0] v_wdata;
  logic [1:0]  v_bmask;

  ram_rmw_ctrl_if #(.ADDR_W(5)) bus1 ();
  ram_rmw_ctrl_if #(.ADDR_W(5)) bus3 ();

  assign bus1.req_valid = v_valid & ~v_sel;
  assign bus1.req_write = v_write;
  assign bus1.req_addr  = v_addr;
  assign bus1.req_wdata = v_wdata;
  assign bus1.req_bmask = v_bmask;
  assign bus3.req_valid = v_valid & v_sel;
  assign bus3.req_write = v_write;
  assign bus3.req_addr  = v_addr;
  assign bus3.req_wdata = v_wdata;
  assign bus3.req_bmask = v_bmask;

  logic [4:0]  raddr1, waddr1, raddr3, waddr3;
  logic [15:0] rdata1, wdata1, rdata3, wdata3;
  logic        write1, write3;
  logic [2:0]  st1, st3;

  ram_rmw_ctrl #(.ADDR_W(5), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .bus(bus1),
    .ram_raddr(raddr1), .ram_rdata(rdata1), .ram_waddr(waddr1),
    .ram_wdata(wdata1), .ram_write(write1), .dbg_state_o(st1)
  );

  ram_rmw_ctrl #(.ADDR_W(5), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .ram_raddr(raddr3), .ram_rdata(rdata3), .ram_waddr(waddr3),
    .ram_wdata(wdata3), .ram_write(write3), .dbg_state_o(st3)
  );

  // ---------------- RAM models ----------------
  logic [15:0] mem1 [32];
  logic [15:0] mem3 [32];
  logic [15:0] p3   [3];

  always @(posedge clk) begin
    if (write1) mem1[waddr1] <= wdata1;
    rdata1 <= mem1[raddr1];
  end

  always @(posedge clk) begin
    if (write3) mem3[waddr3] <= wdata3;
    p3[0] <= mem3[raddr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata3 = p3[2];

  // Observation mux for the selected instance
  logic        m_ready, m_rsp, m_write;
  logic [15:0] m_rdata, m_wdata;
  logic [4:0]  m_waddr;
  logic [2:0]  m_state;
  assign m_ready = v_sel ? bus3.req_ready : bus1.req_ready;
  assign m_rsp   = v_sel ? bus3.rsp_valid : bus1.rsp_valid;
  assign m_rdata = v_sel ? bus3.rsp_rdata : bus1.rsp_rdata;
  assign m_write = v_sel ? write3 : write1;
  assign m_waddr = v_sel ? waddr3 : waddr1;
  assign m_wdata = v_sel ? wdata3 : wdata1;
  assign m_state = v_sel ? st3 : st1;

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          fm_vld [2];
  logic [4:0]  fm_addr[2];

  function automatic bit exp_hit(bit sel, logic [4:0] a);
    return FWD && fm_vld[sel] && (fm_addr[sel] == a);
  endfunction

  function automatic int exp_lat(bit sel, logic w, logic [4:0] a, logic [1:0] m);
    int l;
    bit h;
    l = sel ? 3 : 1;
    h = exp_hit(sel, a);
    if (!w) return h ? 1 : l + 2;
    if (m == 2'b00) return 1;
    if (m == 2'b11) return 2;
    return h ? 2 : l + 3;
  endfunction

  function automatic bit exp_rdacc(bit sel, logic w, logic [4:0] a, logic [1:0] m);
    if (!w) return !exp_hit(sel, a);
    if (m == 2'b00 || m == 2'b11) return 1'b0;
    return !exp_hit(sel, a);
  endfunction

  // ---------------- driver ----------------
  // Issues one request and reports what the DUT did: latency from accept
  // edge to rsp_valid (-1 on timeout), RAM writes seen, whether RD/WAIT was
  // visited, the response data and whether rsp_valid lasted one cycle.
  task automatic txn(input bit sel, input logic w, input logic [4:0] a,
                     input logic [15:0] d, input logic [1:0] m,
                     output int lat, output int nwr, output bit rd_seen,
                     output logic [4:0] wa, output logic [15:0] wd,
                     output logic [15:0] rd, output bit pulse_ok);
    int b;
    @(negedge clk);
    v_sel = sel; v_write = w; v_addr = a; v_wdata = d; v_bmask = m;
    v_valid = 1'b1;
    b = 0;
    while (!m_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    v_valid = 1'b0;
    lat = 0; nwr = 0; rd_seen = 1'b0; wa = '0; wd = '0; rd = '0; pulse_ok = 1'b0;
    while (!m_rsp && lat < 50) begin
      if (m_state == 3'd1 || m_state == 3'd2) rd_seen = 1'b1;
      if (m_write) begin
        nwr++;
        wa = m_waddr;
        wd = m_wdata;
      end
      @(negedge clk);
      lat++;
    end
    if (m_rsp) rd = m_rdata;
    else lat = -1;
    @(negedge clk);
    pulse_ok = !m_rsp;
    if (w && m != 2'b00) begin
      fm_vld[sel]  = 1'b1;
      fm_addr[sel] = a;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.req_ready, bus3.req_ready} !== 2'b00)
      $display("FAIL ready_in_reset got %b exp 00", {bus1.req_ready, bus3.req_ready});
    if ({bus1.req_ready, bus3.req_ready} !== 2'b00) errors++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, write1, raddr1, waddr1, wdata1}
        !== {1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state1 got %h exp %h",
               {bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, write1, raddr1, waddr1, wdata1},
               {1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 16'h0});
    end
    checks++;
    if ({bus3.req_ready, bus3.rsp_valid, bus3.rsp_rdata, write3, raddr3, waddr3, wdata3}
        !== {1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state3 got %h exp %h",
               {bus3.req_ready, bus3.rsp_valid, bus3.rsp_rdata, write3, raddr3, waddr3, wdata3},
               {1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 16'h0});
    end
  endtask

  task automatic test_reset_mid_write();
    int b;
    bit seen_rsp;
    @(negedge clk);
    v_sel = 1'b0; v_write = 1'b1; v_addr = 5'd3; v_wdata = 16'hBEEF; v_bmask = 2'b11;
    v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    b = 0;
    while (!write1 && b < 20) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (write1 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reach_write got %b exp 1", write1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({write1, st1, bus1.req_ready} !== {1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_abort got %b exp %b", {write1, st1, bus1.req_ready}, {1'b0, 3'd0, 1'b0});
    end
    @(negedge clk);
    reset = 1'b0;
    fm_vld[0] = 1'b0;
    fm_vld[1] = 1'b0;
    seen_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus1.rsp_valid) seen_rsp = 1'b1;
    end
    checks++;
    if (seen_rsp !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_rsp got %b exp 0", seen_rsp);
    end
    checks++;
    if (mem1[3] === 16'hBEEF) begin
      errors++;
      $display("FAIL midrst_no_ram_write got %h exp not BEEF", mem1[3]);
    end
    checks++;
    if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, write1, raddr1, waddr1, wdata1}
        !== {1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 16'h0}) begin
      errors++;
      $display("FAIL midrst_after_release got %h exp %h",
               {bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, write1, raddr1, waddr1, wdata1},
               {1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 16'h0});
    end
  endtask

  task automatic test_full_write();
    int lat, nwr, el;
    bit rds, pok;
    logic [4:0] wa;
    logic [15:0] wd, rd;
    el = exp_lat(0, 1'b1, 5'd5, 2'b11);
    txn(0, 1'b1, 5'd5, 16'hA5C3, 2'b11, lat, nwr, rds, wa, wd, rd, pok);
    checks++;
    if (lat != el) begin errors++; $display("FAIL fullwr_latency got %0d exp %0d", lat, el); end
    checks++;
    if ({nwr[3:0], wa, wd} !== {4'd1, 5'd5, 16'hA5C3}) begin
      errors++;
      $display("FAIL fullwr_ram_write got n=%0d a=%0d d=%h exp n=1 a=5 d=A5C3", nwr, wa, wd);
    end
    checks++;
    if ({rds, pok} !== 2'b01) begin
      errors++;
      $display("FAIL fullwr_noread_pulse got %b exp 01", {rds, pok});
    end
  endtask

  task automatic test_read();
    int lat, nwr, el;
    bit rds, pok, erd;
    logic [4:0] wa;
    logic [15:0] wd, rd, e;
    el  = exp_lat(0, 1'b0, 5'd5, 2'b00);
    erd = exp_rdacc(0, 1'b0, 5'd5, 2'b00);
    exp_q.push_back(16'hA5C3);
    txn(0, 1'b0, 5'd5, 16'h0, 2'b00, lat, nwr, rds, wa, wd, rd, pok);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL read_data got %h exp %h", rd, e); end
    checks++;
    if (lat != el) begin errors++; $display("FAIL read_latency got %0d exp %0d", lat, el); end
    checks++;
    if ({rds, pok, nwr[3:0]} !== {erd, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL read_access got %b exp %b", {rds, pok, nwr[3:0]}, {erd, 1'b1, 4'd0});
    end
  endtask

  task automatic test_partial_write();
    int lat, nwr, el;
    bit rds, pok;
    logic [4:0] wa;
    logic [15:0] wd, rd, e;
    logic [1:0]  pm[2];
    logic [15:0] pw[2];
    pm = '{2'b01, 2'b10};
    pw = '{16'hA577, 16'h11C3};
    for (int i = 0; i < 2; i++) begin
      if (i == 1) txn(0, 1'b1, 5'd5, 16'hA5C3, 2'b11, lat, nwr, rds, wa, wd, rd, pok);
      el = exp_lat(0, 1'b1, 5'd5, pm[i]);
      txn(0, 1'b1, 5'd5, 16'h1177, pm[i], lat, nwr, rds, wa, wd, rd, pok);
      checks++;
      if (lat != el) begin errors++; $display("FAIL partial_latency got %0d exp %0d", lat, el); end
      checks++;
      if ({nwr[3:0], wa, wd} !== {4'd1, 5'd5, pw[i]}) begin
        errors++;
        $display("FAIL partial_merge got n=%0d a=%0d d=%h exp n=1 a=5 d=%h", nwr, wa, wd, pw[i]);
      end
      exp_q.push_back(pw[i]);
      txn(0, 1'b0, 5'd5, 16'h0, 2'b00, lat, nwr, rds, wa, wd, rd, pok);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin errors++; $display("FAIL partial_readback got %h exp %h", rd, e); end
    end
  endtask

  task automatic test_zero_mask();
    int lat, nwr;
    bit rds, pok;
    logic [4:0] wa;
    logic [15:0] wd, rd;
    txn(0, 1'b1, 5'd9, 16'hFFFF, 2'b00, lat, nwr, rds, wa, wd, rd, pok);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL zeromask_latency got %0d exp 1", lat); end
    checks++;
    if ({nwr[3:0], rds, pok} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zeromask_no_access got %b exp %b", {nwr[3:0], rds, pok}, {4'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    logic        bw[3];
    logic [4:0]  ba[3];
    logic [15:0] bd[3];
    logic [1:0]  bm[3];
    logic [15:0] e;
    int acc, rsp, cyc;
    bit load_next;
    bw = '{1'b1, 1'b0, 1'b0};
    ba = '{5'd12, 5'd12, 5'd5};
    bd = '{16'h0C0C, 16'h0000, 16'h0000};
    bm = '{2'b11, 2'b00, 2'b00};
    exp_q.push_back(16'h0C0C);
    exp_q.push_back(16'h11C3);
    acc = 0; rsp = 0; cyc = 0;
    @(negedge clk);
    v_sel = 1'b0; v_write = bw[0]; v_addr = ba[0]; v_wdata = bd[0]; v_bmask = bm[0];
    v_valid = 1'b1;
    while (rsp < 3 && cyc < 100) begin
      if (m_rsp) begin
        if (!bw[rsp]) begin
          e = exp_q.pop_front();
          checks++;
          if (m_rdata !== e) begin errors++; $display("FAIL b2b_read_data got %h exp %h", m_rdata, e); end
        end
        rsp++;
      end
      load_next = 1'b0;
      if (v_valid && m_ready) begin
        checks++;
        if (acc != rsp) begin
          errors++;
          $display("FAIL b2b_accept_order got responses=%0d exp %0d before accept", rsp, acc);
        end
        acc++;
        load_next = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (load_next) begin
        if (acc < 3) begin
          v_write = bw[acc]; v_addr = ba[acc]; v_wdata = bd[acc]; v_bmask = bm[acc];
        end else begin
          v_valid = 1'b0;
        end
      end
    end
    v_valid = 1'b0;
    checks++;
    if (acc != 3 || rsp != 3) begin
      errors++;
      $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 3 3", acc, rsp);
    end
    fm_vld[0]  = 1'b1;
    fm_addr[0] = 5'd12;
  endtask

  task automatic test_latency3();
    int lat, nwr, el;
    bit rds, pok;
    logic [4:0] wa;
    logic [15:0] wd, rd, e;
    txn(1, 1'b1, 5'd5, 16'hA5C3, 2'b11, lat, nwr, rds, wa, wd, rd, pok);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL lat3_fullwr_latency got %0d exp 2", lat); end
    txn(1, 1'b1, 5'd6, 16'h1234, 2'b11, lat, nwr, rds, wa, wd, rd, pok);
    el = exp_lat(1, 1'b0, 5'd5, 2'b00);
    exp_q.push_back(16'hA5C3);
    txn(1, 1'b0, 5'd5, 16'h0, 2'b00, lat, nwr, rds, wa, wd, rd, pok);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL lat3_read_data got %h exp %h", rd, e); end
    checks++;
    if (lat != el) begin errors++; $display("FAIL lat3_read_latency got %0d exp %0d", lat, el); end
  endtask

  task automatic test_forward();
    int lat, nwr, el;
    bit rds, pok, erd;
    logic [4:0] wa;
    logic [15:0] wd, rd, e;
    logic [4:0]  ra[2];
    logic [15:0] rv[2];
    ra = '{5'd7, 5'd8};
    rv = '{16'h00FF, 16'h0808};
    txn(0, 1'b1, 5'd8, 16'h0808, 2'b11, lat, nwr, rds, wa, wd, rd, pok);
    txn(0, 1'b1, 5'd7, 16'h00FF, 2'b11, lat, nwr, rds, wa, wd, rd, pok);
    for (int i = 0; i < 2; i++) begin
      el  = exp_lat(0, 1'b0, ra[i], 2'b00);
      erd = exp_rdacc(0, 1'b0, ra[i], 2'b00);
      exp_q.push_back(rv[i]);
      txn(0, 1'b0, ra[i], 16'h0, 2'b00, lat, nwr, rds, wa, wd, rd, pok);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin errors++; $display("FAIL fwd_read_data a=%0d got %h exp %h", ra[i], rd, e); end
      checks++;
      if (lat != el) begin errors++; $display("FAIL fwd_read_latency a=%0d got %0d exp %0d", ra[i], lat, el); end
      checks++;
      if (rds !== erd) begin errors++; $display("FAIL fwd_ram_read a=%0d got %b exp %b", ra[i], rds, erd); end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    v_sel = 1'b0; v_valid = 1'b0; v_write = 1'b0;
    v_addr = '0; v_wdata = '0; v_bmask = '0;
    fm_vld[0] = 1'b0; fm_vld[1] = 1'b0;
    fm_addr[0] = '0; fm_addr[1] = '0;
    test_reset();
    test_reset_mid_write();
    test_full_write();
    test_read();
    test_partial_write();
    test_zero_mask();
    test_back_to_back();
    test_latency3();
    test_forward();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit in case a handshake never completes
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
